systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Operand feeder directly upstream of the N x N PE_UNIT systolic array.
- Buffers one N x N A matrix and one N x N B matrix, received one row pair per beat.
- Clears the array accumulators, then drives the array's left edge (A) and top edge (B) with diagonally skewed operands so PE(i,j) sees A[i][k] and B[k][j] in the same cycle.
- Pulses done_o when every PE accumulator holds its final dot product.

Parameters:
- DATA_WIDTH, 32, operand width; matches the PE up/left width.
- N, 4, array dimension, legal range 2..16.

Ports:
- clk_i, input, 1: clock; all state changes on the rising edge.
- rst_ni, input, 1: synchronous active-low reset.
- in_valid_i, input, 1: row-pair beat valid.
- in_ready_o, output, 1: feeder can accept a beat.
- a_row_i, input, N*DATA_WIDTH: A row r; element c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- b_row_i, input, N*DATA_WIDTH: B row r; same packing.
- left_o, output, N*DATA_WIDTH: lane i drives left_i of PE(i,0).
- up_o, output, N*DATA_WIDTH: lane j drives up_i of PE(0,j).
- arr_rst_no, output, 1: active-low synchronous clear to all PE rst_ni.
- busy_o, output, 1: high in any state except IDLE.
- done_o, output, 1: one-cycle pulse; array results valid.

Behaviour:
- Reset (rst_ni=0 at an edge):
  - state goes to IDLE; beat and stream counters go to 0.
  - left_o=0, up_o=0, arr_rst_no=1, done_o=0, busy_o=0, in_ready_o=1.
  - Operand storage contents are don't-care.
- States: IDLE, LOAD, CLEAR, STREAM, DONE. All outputs are registered.
- IDLE:
  - in_ready_o=1.
  - An accepted beat (in_valid_i & in_ready_o) stores row 0 and moves to LOAD with beat count 1.
- LOAD:
  - in_ready_o=1; each accepted beat stores row r = beat count, then increments the count.
  - Gaps in in_valid_i are allowed and simply stall.
  - Accepting beat N-1 moves to CLEAR and drops in_ready_o for the next cycle.
- CLEAR: exactly one cycle with arr_rst_no=0, left_o=0, up_o=0, then STREAM with t=0.
- STREAM: 3N-2 cycles, t = 0..3N-3.
  - Left lane i presents A[i][t-i] when 0 <= t-i < N, else 0.
  - Up lane j presents B[t-j][j] when 0 <= t-j < N, else 0.
  - Values are visible during cycle t (registered on the edge entering cycle t).
  - After t=3N-3 the state moves to DONE.
- DONE:
  - one cycle with done_o=1 and left_o=up_o=0; then IDLE.
  - By this point the last MAC (PE(N-1,N-1), k=N-1, at cycle 3N-3) has been captured.
- in_ready_o=0 in CLEAR, STREAM and DONE; in_valid_i is ignored there.
- Zero padding is mandatory: the PEs accumulate every cycle, so any non-zero skew filler corrupts results.
- Latency:
  - last accepted beat to done_o = 1 (CLEAR) + 3N-2 (STREAM) + 1 = 3N cycles;
  - N=4: done_o is high 12 cycles after the edge accepting beat 3.
- Reset mid-operation:
  - returns to IDLE immediately with the reset values above; no done_o.
  - Partial storage is discarded logically; the next job restarts at row 0.
- Arithmetic: pure data movement, no width change.
- Counter widths: clog2(N) bits for beats, clog2(3N-2) bits for t.
- A new job may begin in IDLE the cycle after DONE.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, CLEAR, STREAM, DONE);
  - localparam STREAM_LEN = 3*N-2;
  - lane slice helper constants.
- One sub-module, skew_lane_mux:
  - per-lane selector with parameters DATA_WIDTH, N and lane index L;
  - inputs: t and one stored row or column;
  - output: element t-L, or 0 when out of range.
  - Instantiated N times for A lanes and N times for B lanes.

Test Plan:
- N=4, back-to-back beats:
  - A = identity, B[r][c] = 10r+c.
  - Expect arr_rst_no=0 for 1 cycle, then 10 STREAM cycles.
  - At t=0: left lane 0 = 1, up lane 0 = 0; at t=1: up lane 1 = 1, up lane 0 = 10.
  - done_o on cycle 12 after the last beat; array res_o(i,j) = 10i+j.
- N=4, all-ones A and B:
  - every skew filler position observed as 0;
  - final res_o = 4 in every PE.
- Valid gaps: beats at cycles 0, 3, 4, 9.
  - in_ready_o stays high through LOAD and CLEAR starts after the 4th beat.
  - Extra in_valid_i during STREAM is not accepted; the next job still loads row 0 correctly.
- Reset mid-STREAM at t=5:
  - next cycle left_o=up_o=0, busy_o=0, in_ready_o=1, no done_o.
  - A following full job produces correct results.
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - stream length 4; done_o 6 cycles after the last beat;
  - res_o = [[19,22],[43,50]].

Source files
------------

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and sizing helpers for the systolic operand feeder.
// The feeder and its lane selectors derive all counter widths from here.
package systolic_skew_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  localparam int N_MIN              = 2;
  localparam int N_MAX              = 16;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int N_DEFAULT          = 4;
  localparam int STREAM_LEN_DEFAULT = 3 * N_DEFAULT - 2;

  // Number of cycles needed to push a full skewed diagonal wavefront through.
  function automatic int stream_len(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int beat_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int t_width(input int n);
    return $clog2(3 * n - 2);
  endfunction

  // Low bit of element/lane 'lane' inside a packed row of 'dw'-bit elements.
  function automatic int lane_lo(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Row-pair load handshake plus array-edge drive bundle for the skew feeder.
interface systolic_skew_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) ();

  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [N*DATA_WIDTH-1:0] a_row_i;
  logic [N*DATA_WIDTH-1:0] b_row_i;
  logic [N*DATA_WIDTH-1:0] left_o;
  logic [N*DATA_WIDTH-1:0] up_o;
  logic                    arr_rst_no;
  logic                    busy_o;
  logic                    done_o;

  modport slave (
    input  in_valid_i, a_row_i, b_row_i,
    output in_ready_o, left_o, up_o, arr_rst_no, busy_o, done_o
  );

  modport master (
    output in_valid_i, a_row_i, b_row_i,
    input  in_ready_o, left_o, up_o, arr_rst_no, busy_o, done_o
  );

endinterface

// File: rtl/systolic_skew_feeder_skew_lane_mux.sv
// Per-lane skew selector: picks element (t - L) of a stored vector, or zero
// when the lane's diagonal has not yet started or has already drained.
module skew_lane_mux
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter int L          = 0,
  parameter int TW         = 4
) (
  input  logic [TW-1:0]           t,
  input  logic [N*DATA_WIDTH-1:0] vec,
  output logic [DATA_WIDTH-1:0]   elem
);

  // One-hot AND-OR select; no hit leaves the zero padding the PEs rely on.
  always_comb begin
    elem = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < N; k++) begin
      elem = elem | (vec[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH]
                     & {DATA_WIDTH{(int'(t) == (L + k))}});
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for an N x N systolic array: buffers A and B row by row,
// clears the PE accumulators, then streams diagonally skewed edge operands.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  systolic_skew_feeder_if.slave bus
);

  localparam int STREAM_LEN = stream_len(N);
  localparam int BW         = beat_width(N);
  localparam int TW         = t_width(N);
  localparam int RW         = N * DATA_WIDTH;

  localparam logic [TW-1:0] T_LAST    = TW'(STREAM_LEN - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);

  feeder_state_e   state_r;
  logic [BW-1:0]   beat_cnt_r;
  logic [TW-1:0]   t_r;
  logic [TW-1:0]   t_next_s;
  logic [RW-1:0]   a_mem_r [N];
  logic [RW-1:0]   b_mem_r [N];
  logic [RW-1:0]   b_col_s [N];
  logic [DATA_WIDTH-1:0] a_lane_s [N];
  logic [DATA_WIDTH-1:0] b_lane_s [N];
  logic [RW-1:0]   left_next_s;
  logic [RW-1:0]   up_next_s;
  logic [RW-1:0]   left_r;
  logic [RW-1:0]   up_r;
  logic            in_ready_r;
  logic            arr_rst_n_r;
  logic            busy_r;
  logic            done_r;
  logic            accept_s;

  assign accept_s = bus.in_valid_i & in_ready_r;

  // Stream index that will be visible after the next edge (0 when leaving CLEAR).
  always_comb begin
    t_next_s = {TW{1'b0}};
    if (state_r == ST_STREAM) begin
      t_next_s = t_r + TW'(1);
    end else begin
      t_next_s = {TW{1'b0}};
    end
  end

  // Transpose stored B rows so each up lane sees its own column.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      b_col_s[j] = {RW{1'b0}};
      for (int k = 0; k < N; k++) begin
        b_col_s[j][lane_lo(k, DATA_WIDTH) +: DATA_WIDTH] =
          b_mem_r[k][lane_lo(j, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .L          (g),
      .TW         (TW)
    ) u_a_lane (
      .t    (t_next_s),
      .vec  (a_mem_r[g]),
      .elem (a_lane_s[g])
    );

    skew_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .L          (g),
      .TW         (TW)
    ) u_b_lane (
      .t    (t_next_s),
      .vec  (b_col_s[g]),
      .elem (b_lane_s[g])
    );
  end

  // Pack the per-lane selections into the edge buses.
  always_comb begin
    left_next_s = {RW{1'b0}};
    up_next_s   = {RW{1'b0}};
    for (int i = 0; i < N; i++) begin
      left_next_s[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = a_lane_s[i];
      up_next_s[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]   = b_lane_s[i];
    end
  end

  // Operand storage; contents after reset are irrelevant because the beat
  // counter restarts at row 0.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      a_mem_r[beat_cnt_r] <= bus.a_row_i;
      b_mem_r[beat_cnt_r] <= bus.b_row_i;
    end
  end

  // Sequencer with registered handshake, edge-drive and status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      beat_cnt_r  <= {BW{1'b0}};
      t_r         <= {TW{1'b0}};
      left_r      <= {RW{1'b0}};
      up_r        <= {RW{1'b0}};
      in_ready_r  <= 1'b1;
      arr_rst_n_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            beat_cnt_r <= BW'(1);
            busy_r     <= 1'b1;
            state_r    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (beat_cnt_r == BEAT_LAST) begin
              beat_cnt_r  <= {BW{1'b0}};
              in_ready_r  <= 1'b0;
              arr_rst_n_r <= 1'b0;
              left_r      <= {RW{1'b0}};
              up_r        <= {RW{1'b0}};
              state_r     <= ST_CLEAR;
            end else begin
              beat_cnt_r <= beat_cnt_r + BW'(1);
            end
          end
        end
        ST_CLEAR: begin
          arr_rst_n_r <= 1'b1;
          t_r         <= {TW{1'b0}};
          left_r      <= left_next_s;
          up_r        <= up_next_s;
          state_r     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (t_r == T_LAST) begin
            t_r     <= {TW{1'b0}};
            left_r  <= {RW{1'b0}};
            up_r    <= {RW{1'b0}};
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            t_r    <= t_r + TW'(1);
            left_r <= left_next_s;
            up_r   <= up_next_s;
          end
        end
        ST_DONE: begin
          done_r     <= 1'b0;
          busy_r     <= 1'b0;
          in_ready_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          beat_cnt_r  <= {BW{1'b0}};
          t_r         <= {TW{1'b0}};
          left_r      <= {RW{1'b0}};
          up_r        <= {RW{1'b0}};
          in_ready_r  <= 1'b1;
          arr_rst_n_r <= 1'b1;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready_o = in_ready_r;
  assign bus.left_o     = left_r;
  assign bus.up_o       = up_r;
  assign bus.arr_rst_no = arr_rst_n_r;
  assign bus.busy_o     = busy_r;
  assign bus.done_o     = done_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for the skew feeder: N=4 and N=2 instances, each driving
// a behavioural PE array whose accumulators are compared at done_o.
module tb_systolic_skew_feeder;

  localparam int DW = 32;
  typedef logic [DW-1:0] word_t;
  typedef struct packed {
    logic [4*DW-1:0] left;
    logic [4*DW-1:0] up;
  } lane_exp_t;

  logic clk;
  logic rst_n [2];
  logic vld_d [2];
  word_t arow_d [2][4];
  word_t brow_d [2][4];

  logic [4*DW-1:0] left_p [2];
  logic [4*DW-1:0] up_p [2];
  logic rdy_v [2];
  logic arst_v [2];
  logic busy_v [2];
  logic done_v [2];

  word_t mat_a [4][4];
  word_t mat_b [4][4];
  word_t exp_r [4][4];

  lane_exp_t         lane_q [$];
  logic [16*DW-1:0]  res_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode [2];
  int tcnt [2];
  int last_beat_cyc [2];

  bit [31:0] acc  [2][4][4];
  bit [31:0] hreg [2][4][4];
  bit [31:0] vreg [2][4][4];
  bit [31:0] lin_c [2][4][4];
  bit [31:0] uin_c [2][4][4];

  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(4)) bus4 ();
  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(2)) bus2 ();

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(4)) u_dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n[0]),
    .bus    (bus4)
  );

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(2)) u_dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n[1]),
    .bus    (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc++;

  assign bus4.in_valid_i = vld_d[0];
  assign bus2.in_valid_i = vld_d[1];

  always_comb begin
    bus4.a_row_i = '0;
    bus4.b_row_i = '0;
    bus2.a_row_i = '0;
    bus2.b_row_i = '0;
    for (int l = 0; l < 4; l++) begin
      bus4.a_row_i[l*DW +: DW] = arow_d[0][l];
      bus4.b_row_i[l*DW +: DW] = brow_d[0][l];
    end
    for (int l = 0; l < 2; l++) begin
      bus2.a_row_i[l*DW +: DW] = arow_d[1][l];
      bus2.b_row_i[l*DW +: DW] = brow_d[1][l];
    end
  end

  always_comb begin
    left_p[0] = bus4.left_o;
    up_p[0]   = bus4.up_o;
    left_p[1] = {{(2*DW){1'b0}}, bus2.left_o};
    up_p[1]   = {{(2*DW){1'b0}}, bus2.up_o};
    rdy_v[0]  = bus4.in_ready_o;  rdy_v[1]  = bus2.in_ready_o;
    arst_v[0] = bus4.arr_rst_no;  arst_v[1] = bus2.arr_rst_no;
    busy_v[0] = bus4.busy_o;      busy_v[1] = bus2.busy_o;
    done_v[0] = bus4.done_o;      done_v[1] = bus2.done_o;
  end

  // Behavioural downstream PE array: operands hop one PE per cycle.
  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          lin_c[d][i][j] = 32'd0;
          uin_c[d][i][j] = 32'd0;
          if (j == 0) lin_c[d][i][j] = left_p[d][i*DW +: DW];
          else        lin_c[d][i][j] = hreg[d][i][j-1];
          if (i == 0) uin_c[d][i][j] = up_p[d][j*DW +: DW];
          else        uin_c[d][i][j] = vreg[d][i-1][j];
        end
  end

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          hreg[d][i][j] <= lin_c[d][i][j];
          vreg[d][i][j] <= uin_c[d][i][j];
          acc[d][i][j]  <= (arst_v[d] === 1'b0) ? 32'd0
                           : acc[d][i][j] + lin_c[d][i][j] * uin_c[d][i][j];
        end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: consumes expected lanes during STREAM and results at done_o.
  initial begin
    lane_exp_t e;
    logic [16*DW-1:0] r_exp, r_act;
    int n;
    mode = '{0, 0};
    tcnt = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n = (d == 0) ? 4 : 2;
        if (mode[d] == 1) begin
          checks++;
          if (lane_q.size() == 0) begin
            errors++;
            $display("FAIL lane_underflow dut=%0d t=%0d", d, tcnt[d]);
          end else begin
            e = lane_q.pop_front();
            if (left_p[d] !== e.left || up_p[d] !== e.up || arst_v[d] !== 1'b1) begin
              errors++;
              $display("FAIL stream dut=%0d t=%0d: got left=%h up=%h arst=%b expected left=%h up=%h arst=1",
                       d, tcnt[d], left_p[d], up_p[d], arst_v[d], e.left, e.up);
            end
          end
          tcnt[d]++;
          if (tcnt[d] == 3*n - 2) mode[d] = 2;
        end else if (mode[d] == 2) begin
          chk("done_cycle", {done_v[d], |left_p[d], |up_p[d]}, 128'd4);
          chk("done_latency", 128'(cyc - last_beat_cyc[d]), 128'(3*n));
          checks++;
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL result_underflow dut=%0d", d);
          end else begin
            r_exp = res_q.pop_front();
            r_act = '0;
            for (int i = 0; i < n; i++)
              for (int j = 0; j < n; j++)
                r_act[(i*4+j)*DW +: DW] = acc[d][i][j];
            if (r_act !== r_exp) begin
              errors++;
              $display("FAIL result dut=%0d: got %h expected %h", d, r_act, r_exp);
            end
          end
          mode[d] = 0;
        end else begin
          if (done_v[d] === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done dut=%0d: got 1 expected 0", d);
          end
          if (arst_v[d] === 1'b0 && rst_n[d] === 1'b1) begin
            chk("clear_lanes_zero", 128'(|{left_p[d], up_p[d]}), 128'd0);
            mode[d] = 1;
            tcnt[d] = 0;
          end
        end
        if (rst_n[d] === 1'b0) mode[d] = 0;
      end
    end
  end

  // Driver: pushes expectations, then loads N row pairs. Entered at posedge+1.
  task automatic run_job(input int d, input bit gapped, input int rst_t, input bit junk);
    int n;
    int gaps [4];
    int k;
    lane_exp_t e;
    logic [16*DW-1:0] r;
    n = (d == 0) ? 4 : 2;
    gaps = gapped ? '{0, 2, 0, 4} : '{0, 0, 0, 0};
    for (int t = 0; t < 3*n - 2; t++) begin
      if (rst_t < 0 || t <= rst_t) begin
        e = '0;
        for (int i = 0; i < n; i++) begin
          if (t - i >= 0 && t - i < n) begin
            e.left[i*DW +: DW] = mat_a[i][t-i];
            e.up[i*DW +: DW]   = mat_b[t-i][i];
          end
        end
        lane_q.push_back(e);
      end
    end
    if (rst_t < 0) begin
      r = '0;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          r[(i*4+j)*DW +: DW] = exp_r[i][j];
      res_q.push_back(r);
    end
    for (int row = 0; row < n; row++) begin
      for (int g = 0; g < gaps[row]; g++) begin
        @(posedge clk); #1;
        chk("ready_in_gap", 128'(rdy_v[d]), 128'd1);
      end
      vld_d[d] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        arow_d[d][c] = mat_a[row][c];
        brow_d[d][c] = mat_b[row][c];
      end
      chk("ready_at_beat", 128'(rdy_v[d]), 128'd1);
      last_beat_cyc[d] = cyc;
      @(posedge clk); #1;
      vld_d[d] = 1'b0;
    end
    if (junk) begin
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        vld_d[d] = 1'b1;
        for (int c = 0; c < 4; c++) begin
          arow_d[d][c] = 32'hDEAD_0000 + 32'(c);
          brow_d[d][c] = 32'hBEEF_0000 + 32'(c);
        end
        chk("ready_low_in_stream", 128'(rdy_v[d]), 128'd0);
      end
      @(posedge clk); #1;
      vld_d[d] = 1'b0;
    end
    if (rst_t >= 0) begin
      for (int j = 0; j <= rst_t; j++) begin
        @(posedge clk); #1;
      end
      rst_n[d] = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_lanes", 128'(|{left_p[d], up_p[d]}), 128'd0);
      chk("post_rst_status", {busy_v[d], rdy_v[d], done_v[d], arst_v[d]}, 128'b0101);
      rst_n[d] = 1'b1;
    end else begin
      for (k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (busy_v[d] === 1'b0 && mode[d] == 0) break;
      end
      if (k == 200) begin
        checks++;
        errors++;
        $display("FAIL job_timeout dut=%0d: busy stuck after %0d cycles", d, k);
      end
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 32'd0;
        mat_b[i][j] = 32'd0;
        exp_r[i][j] = 32'd0;
      end
  endtask

  initial begin
    rst_n = '{1'b0, 1'b0};
    vld_d = '{1'b0, 1'b0};
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        arow_d[d][c] = 32'd0;
        brow_d[d][c] = 32'd0;
      end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_lanes", 128'(|{left_p[d], up_p[d]}), 128'd0);
      chk("reset_status", {busy_v[d], rdy_v[d], done_v[d], arst_v[d]}, 128'b0101);
    end
    rst_n = '{1'b1, 1'b1};
    @(posedge clk); #1;

    // Identity A, B[r][c] = 10r+c: result equals B.
    clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = (i == j) ? 32'd1 : 32'd0;
        mat_b[i][j] = 32'(10*i + j);
        exp_r[i][j] = 32'(10*i + j);
      end
    run_job(0, 1'b0, -1, 1'b0);

    // All ones: every PE sums four ones; skew filler must be zero.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 32'd1;
        mat_b[i][j] = 32'd1;
        exp_r[i][j] = 32'd4;
      end
    run_job(0, 1'b0, -1, 1'b0);

    // Gapped beats, junk valid during STREAM; A=r+c, B=2I gives 2(i+j).
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 32'(i + j);
        mat_b[i][j] = (i == j) ? 32'd2 : 32'd0;
        exp_r[i][j] = 32'(2*(i + j));
      end
    run_job(0, 1'b1, -1, 1'b1);

    // Next job must load from row 0 again: identity times B.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = (i == j) ? 32'd1 : 32'd0;
        mat_b[i][j] = 32'(4*i + j + 1);
        exp_r[i][j] = 32'(4*i + j + 1);
      end
    run_job(0, 1'b0, -1, 1'b0);

    // Reset while streaming t=5.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 32'd7;
        mat_b[i][j] = 32'd3;
      end
    run_job(0, 1'b0, 5, 1'b0);

    // Full job after reset: A[i][k]=i+1, B ones gives 4(i+1).
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        mat_a[i][j] = 32'(i + 1);
        mat_b[i][j] = 32'd1;
        exp_r[i][j] = 32'(4*(i + 1));
      end
    run_job(0, 1'b0, -1, 1'b0);

    // N=2 worked example.
    clear_mats();
    mat_a[0][0] = 32'd1; mat_a[0][1] = 32'd2; mat_a[1][0] = 32'd3; mat_a[1][1] = 32'd4;
    mat_b[0][0] = 32'd5; mat_b[0][1] = 32'd6; mat_b[1][0] = 32'd7; mat_b[1][1] = 32'd8;
    exp_r[0][0] = 32'd19; exp_r[0][1] = 32'd22; exp_r[1][0] = 32'd43; exp_r[1][1] = 32'd50;
    run_job(1, 1'b0, -1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(lane_q.size() + res_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
